// File: rtl/ddfs_range_ctrl_if.sv
// Board-side bundle for the DDFS range controller: raw buttons and divider
// feedback in, range code / update strobe / busy out.
interface ddfs_range_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       div_clk;
  logic [2:0] freq_cntrl;
  logic       update;
  logic       busy;

  modport master (
    output btn_up, btn_down, div_clk,
    input  freq_cntrl, update, busy
  );

  modport slave (
    input  btn_up, btn_down, div_clk,
    output freq_cntrl, update, busy
  );
endinterface

// File: rtl/ddfs_range_ctrl.sv
// Push-button range stepper for the DDFS divider; applies the new code only at a divider edge.
// Define DDFS_RANGE_WRAP_EN to wrap 6<->0 instead of saturating at the ends.
//
// state       | meaning
// S_IDLE      | no button activity, counter cleared
// S_DEBOUNCE  | one button high, counting stable cycles
// S_WAIT_EDGE | press accepted, waiting for div_clk rise or timeout
// S_COMMIT    | load freq_cntrl with target, pulse update
// S_HOLD      | wait for both buttons released for a full debounce time
module ddfs_range_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_TIMEOUT    = 1048575,
  parameter int CNT_W           = 20,
  parameter int RESET_RANGE     = 3
) (
  input  logic              clk_in,
  input  logic              rst_n,
  ddfs_range_ctrl_if.slave  bus
);

  localparam logic [2:0]       LP_MAX     = 3'd6;
  localparam logic [2:0]       LP_RESET   = (RESET_RANGE > 6) ? 3'd6 : 3'(RESET_RANGE);
  localparam logic [CNT_W-1:0] LP_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_TO_LAST = CNT_W'(EDGE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_WAIT_EDGE,
    S_COMMIT,
    S_HOLD
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_dir_up, w_dir_up_nxt;
  logic [2:0]       r_target, w_target_nxt;
  logic [2:0]       r_freq;
  logic             r_update;
  logic [2:0]       w_step;
  logic             w_press_ok;
  logic             w_edge;

  logic r_up_s1, r_up_s2, r_dn_s1, r_dn_s2;
  logic r_div_s1, r_div_s2, r_div_prev;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_up_s1    <= 1'b0;
      r_up_s2    <= 1'b0;
      r_dn_s1    <= 1'b0;
      r_dn_s2    <= 1'b0;
      r_div_s1   <= 1'b0;
      r_div_s2   <= 1'b0;
      r_div_prev <= 1'b0;
    end else begin
      r_up_s1    <= bus.btn_up;
      r_up_s2    <= r_up_s1;
      r_dn_s1    <= bus.btn_down;
      r_dn_s2    <= r_dn_s1;
      r_div_s1   <= bus.div_clk;
      r_div_s2   <= r_div_s1;
      r_div_prev <= r_div_s2;
    end
  end

  assign w_edge     = r_div_s2 & ~r_div_prev;
  assign w_press_ok = r_dir_up ? (r_up_s2 & ~r_dn_s2) : (r_dn_s2 & ~r_up_s2);

  // Next range code in the latched direction; the ends either hold or wrap.
  always_comb begin
    w_step = r_freq;
    if (r_dir_up) begin
      if (r_freq >= LP_MAX) begin
`ifdef DDFS_RANGE_WRAP_EN
        w_step = 3'd0;
`else
        w_step = LP_MAX;
`endif
      end else begin
        w_step = r_freq + 3'd1;
      end
    end else begin
      if (r_freq == 3'd0) begin
`ifdef DDFS_RANGE_WRAP_EN
        w_step = LP_MAX;
`else
        w_step = 3'd0;
`endif
      end else begin
        w_step = r_freq - 3'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_dir_up <= 1'b0;
      r_target <= LP_RESET;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dir_up <= w_dir_up_nxt;
      r_target <= w_target_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_dir_up_nxt = r_dir_up;
    w_target_nxt = r_target;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (r_up_s2 ^ r_dn_s2) begin
          w_state_nxt  = S_DEBOUNCE;
          w_dir_up_nxt = r_up_s2;
        end
      end
      S_DEBOUNCE: begin
        if (!w_press_ok) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_DB_LAST) begin
          w_cnt_nxt    = '0;
          w_target_nxt = w_step;
          // A press at a saturated end produces no step and no update.
          w_state_nxt  = (w_step == r_freq) ? S_HOLD : S_WAIT_EDGE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_EDGE: begin
        if (w_edge || (r_cnt == LP_TO_LAST)) begin
          w_state_nxt = S_COMMIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_COMMIT: begin
        w_state_nxt = S_HOLD;
        w_cnt_nxt   = '0;
      end
      S_HOLD: begin
        if (r_up_s2 || r_dn_s2) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LP_DB_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_freq   <= LP_RESET;
      r_update <= 1'b0;
    end else begin
      r_update <= (r_state == S_COMMIT);
      if (r_state == S_COMMIT) begin
        r_freq <= r_target;
      end
    end
  end

  assign bus.freq_cntrl = r_freq;
  assign bus.update     = r_update;
  assign bus.busy       = (r_state == S_WAIT_EDGE) || (r_state == S_COMMIT) || (r_state == S_HOLD);

endmodule

// File: tb/tb_ddfs_range_ctrl.sv
// Bench for ddfs_range_ctrl: directed timing checks plus randomized presses
// scored against a press-level range model.
module tb_ddfs_range_ctrl;
  localparam int DB = 4;
  localparam int TO = 16;
  localparam int RR = 3;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  ddfs_range_ctrl_if bus ();

  ddfs_range_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .EDGE_TIMEOUT    (TO),
    .CNT_W           (20),
    .RESET_RANGE     (RR)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_upd    = 0;
  logic [2:0] prev_freq;
  bit         div_auto = 1'b0;
  int         div_half = 3;
  int         div_cnt  = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One model step of the range code for a single accepted press.
  function automatic int model_step(input int code, input bit up);
`ifdef DDFS_RANGE_WRAP_EN
    if (up) return (code == 6) ? 0 : code + 1;
    return (code == 0) ? 6 : code - 1;
`else
    if (up) return (code == 6) ? 6 : code + 1;
    return (code == 0) ? 0 : code - 1;
`endif
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk_in);
      if (div_auto) begin
        div_cnt++;
        if (div_cnt >= div_half) begin
          div_cnt     = 0;
          bus.div_clk = ~bus.div_clk;
        end
      end
    end
  endtask

  task automatic wait_busy(input string tag, input int max_cyc);
    int k = 0;
    while (!bus.busy && k < max_cyc) begin
      step(1);
      k++;
    end
    chk(tag, int'(bus.busy), 1);
  endtask

  task automatic press(input bit up, input int hold);
    if (up) bus.btn_up = 1'b1; else bus.btn_down = 1'b1;
    step(hold);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    step(30);
  endtask

  // Every update must coincide with a code change and vice versa; code never exceeds 6.
  initial forever begin
    @(posedge clk_in);
    #2;
    if (!rst_n) begin
      prev_freq = bus.freq_cntrl;
    end else begin
      if (bus.update) n_upd++;
      if (bus.update || bus.freq_cntrl != prev_freq)
        chk("upd_align", int'(bus.update), int'(bus.freq_cntrl != prev_freq));
      if (bus.freq_cntrl != prev_freq)
        chk("range_le6", int'(bus.freq_cntrl <= 3'd6), 1);
      prev_freq = bus.freq_cntrl;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int code;
    int old;
    bit up;
    int nb;

    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    bus.div_clk  = 1'b0;
    rst_n        = 1'b0;
    step(3);
    chk("rst_freq", int'(bus.freq_cntrl), RR);
    chk("rst_update", int'(bus.update), 0);
    chk("rst_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    step(3);
    chk("post_rst_freq", int'(bus.freq_cntrl), RR);

    // Held up press with a running divider: one step, no auto-repeat.
    base     = n_upd;
    div_auto = 1'b1;
    div_half = 3;
    bus.btn_up = 1'b1;
    step(20);
    chk("up_freq", int'(bus.freq_cntrl), 4);
    chk("up_nupd", n_upd - base, 1);
    chk("up_busy_held", int'(bus.busy), 1);
    step(20);
    chk("up_no_repeat", n_upd - base, 1);
    bus.btn_up = 1'b0;
    step(10);
    chk("up_busy_rel", int'(bus.busy), 0);

    // Bouncing down press, then exact divider-edge latency.
    div_auto    = 1'b0;
    bus.div_clk = 1'b0;
    step(3);
    bus.btn_down = 1'b1; step(2);
    bus.btn_down = 1'b0; step(1);
    bus.btn_down = 1'b1; step(4);
    chk("bounce_not_yet", int'(bus.busy), 0);
    wait_busy("bounce_accept", 8);
    step(2);
    bus.div_clk = 1'b1;
    step(3);
    chk("edge_lat_before", int'(bus.freq_cntrl), 4);
    step(1);
    chk("edge_lat_freq", int'(bus.freq_cntrl), 3);
    chk("edge_lat_upd", int'(bus.update), 1);
    step(1);
    chk("edge_upd_1cyc", int'(bus.update), 0);
    bus.btn_down = 1'b0;
    bus.div_clk  = 1'b0;
    step(10);

    // Stalled divider: timeout forces the commit.
    base = n_upd;
    bus.btn_up = 1'b1;
    wait_busy("to_accept", 12);
    step(TO);
    chk("to_early", int'(bus.freq_cntrl), 3);
    step(1);
    chk("to_freq", int'(bus.freq_cntrl), 4);
    chk("to_upd", int'(bus.update), 1);
    bus.btn_up = 1'b0;
    step(10);
    chk("to_nupd", n_upd - base, 1);

    // Both buttons together are ignored.
    base = n_upd;
    bus.btn_up   = 1'b1;
    bus.btn_down = 1'b1;
    step(12);
    chk("both_busy", int'(bus.busy), 0);
    chk("both_freq", int'(bus.freq_cntrl), 4);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    step(5);
    chk("both_nupd", n_upd - base, 0);

    // Press at the top of the range.
    div_auto = 1'b1;
    div_half = 2;
    press(1'b1, 25);
    press(1'b1, 25);
    chk("reach_top", int'(bus.freq_cntrl), 6);
    base = n_upd;
    bus.btn_up = 1'b1;
    step(12);
    chk("top_busy", int'(bus.busy), 1);
    step(10);
    bus.btn_up = 1'b0;
    step(10);
`ifdef DDFS_RANGE_WRAP_EN
    chk("top_freq", int'(bus.freq_cntrl), 0);
    chk("top_nupd", n_upd - base, 1);
`else
    chk("top_freq", int'(bus.freq_cntrl), 6);
    chk("top_nupd", n_upd - base, 0);
`endif

    // Reset while waiting for a divider edge drops the pending step.
    div_auto    = 1'b0;
    bus.div_clk = 1'b0;
    step(2);
    bus.btn_down = 1'b1;
    wait_busy("rstw_accept", 12);
    step(3);
    rst_n = 1'b0;
    #1;
    chk("rstw_freq", int'(bus.freq_cntrl), RR);
    chk("rstw_busy", int'(bus.busy), 0);
    chk("rstw_upd", int'(bus.update), 0);
    bus.btn_down = 1'b0;
    step(3);
    rst_n    = 1'b1;
    base     = n_upd;
    div_auto = 1'b1;
    step(40);
    chk("rstw_nupd", n_upd - base, 0);
    chk("rstw_freq_after", int'(bus.freq_cntrl), RR);

    // Randomized presses with short bounces and varying divider rate.
    code = RR;
    for (int i = 0; i < 30; i++) begin
      up       = 1'($urandom_range(0, 1));
      nb       = $urandom_range(0, 2);
      div_half = $urandom_range(1, 4);
      base     = n_upd;
      old      = code;
      for (int b = 0; b < nb; b++) begin
        if (up) bus.btn_up = 1'b1; else bus.btn_down = 1'b1;
        step($urandom_range(1, 2));
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        step($urandom_range(1, 2));
      end
      press(up, $urandom_range(12, 25));
      code = model_step(code, up);
      chk("rand_code", int'(bus.freq_cntrl), code);
      chk("rand_nupd", n_upd - base, int'(code != old));
      chk("rand_idle", int'(bus.busy), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
